// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and the request record.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic                  we;
  } req_t;

endpackage

// File: rtl/dmarb_grant.sv
// Winner select for the two requesters. Fixed priority (port 0 first) by default;
// defining DMARB_ROUND_ROBIN_EN adds a 1-bit preferred-port pointer.
module dmarb_grant
  import data_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_take,
  output logic o_grant_id,
  output logic o_grant_valid
);

  assign o_grant_valid = i_valid0 | i_valid1;

`ifdef DMARB_ROUND_ROBIN_EN
  logic r_ptr;

  // After a grant the other port becomes preferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= PORT_CPU;
    end else if (i_take && o_grant_valid) begin
      r_ptr <= ~o_grant_id;
    end
  end

  always_comb begin
    o_grant_id = PORT_CPU;
    if (i_valid0 && i_valid1) begin
      o_grant_id = r_ptr;
    end else if (i_valid1) begin
      o_grant_id = PORT_DMA;
    end
  end
`else
  logic w_unused;
  assign w_unused   = &{1'b0, clk, reset, i_take};
  assign o_grant_id = i_valid0 ? PORT_CPU : (i_valid1 ? PORT_DMA : PORT_CPU);
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory: accept, one access cycle,
// one response cycle. Optional round-robin arbitration via DMARB_ROUND_ROBIN_EN (see dmarb_grant).
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = REQ_ADDR_W,
  parameter int DATA_W    = REQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  state_t            w_state_next;
  req_t              w_sel;
  req_t              r_req;
  logic              r_id;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic              w_grant_id;
  logic              w_grant_valid;
  logic              w_take;
  logic              w_err;

  assign w_take = (r_state == IDLE) && w_grant_valid;

  dmarb_grant u_grant (
    .clk          (clk),
    .reset        (reset),
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_take       (w_take),
    .o_grant_id   (w_grant_id),
    .o_grant_valid(w_grant_valid)
  );

  assign w_sel = (w_grant_id == PORT_DMA) ? {req1_addr, req1_wdata, req1_we}
                                          : {req0_addr, req0_wdata, req0_we};
  assign w_err = (w_sel.addr[1:0] != 2'b00) || (w_sel.addr >= ADDR_W'(MEM_BYTES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= '0;
      r_id    <= PORT_CPU;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_req <= w_sel;
        r_id  <= w_grant_id;
        r_err <= w_err;
      end
      // Writes and rejected requests return zero data.
      if (r_state == ACCESS) begin
        r_rdata <= (!r_err && !r_req.we) ? mem_rdata : '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    rsp0_valid   = 1'b0;
    rsp0_rdata   = '0;
    rsp0_err     = 1'b0;
    rsp1_valid   = 1'b0;
    rsp1_rdata   = '0;
    rsp1_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_next = ACCESS;
          req0_ready   = (w_grant_id == PORT_CPU);
          req1_ready   = (w_grant_id == PORT_DMA);
        end
      end
      ACCESS: begin
        w_state_next = RESP;
        if (!r_err) begin
          mem_addr  = r_req.addr;
          mem_wdata = r_req.wdata;
          mem_write = r_req.we;
          mem_read  = !r_req.we;
        end
      end
      RESP: begin
        w_state_next = IDLE;
        if (r_id == PORT_CPU) begin
          rsp0_valid = 1'b1;
          rsp0_rdata = r_rdata;
          rsp0_err   = r_err;
        end else begin
          rsp1_valid = 1'b1;
          rsp1_rdata = r_rdata;
          rsp1_err   = r_err;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter (default fixed-priority build): vector table plus hand-written
// contention and mid-access reset sequences; responses are checked through a scoreboard queue.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MEM_BYTES(256), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Memory fixture: word i starts as 0x1000_0000 + i, combinational read, write on the edge.
  logic        mem_init;
  logic [31:0] mem_model [0:63];
  assign mem_rdata = mem_model[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_write) begin
      mem_model[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp0_valid=%0b rsp1_valid=%0b expected none",
                   rsp0_valid, rsp1_valid);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_port", 32'(rsp1_valid), 32'(e.port));
          chk("rsp_err", 32'(e.port ? rsp1_err : rsp0_err), 32'(e.err));
          chk("rsp_rdata", e.port ? rsp1_rdata : rsp0_rdata, e.rdata);
          $display("rsp port=%0d err=%0b rdata=%h", e.port, e.err, e.port ? rsp1_rdata : rsp0_rdata);
        end
      end else begin
        chk("rsp_idle_zero", rsp0_rdata | rsp1_rdata | 32'(rsp0_err) | 32'(rsp1_err), 32'd0);
      end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic do_req(input vec_t v);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    drive(v.port, v.we, v.addr, v.wdata);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (v.port ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("ready_seen", 32'(got), 32'd1);
    if (!got) begin
      idle_inputs();
      return;
    end
    chk("other_ready", 32'(v.port ? req0_ready : req1_ready), 32'd0);
    sb.push_back('{port: v.port, err: v.exp_err, rdata: v.exp_rdata});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    if (v.exp_err) begin
      chk("err_mem_read", 32'(mem_read), 32'd0);
      chk("err_mem_write", 32'(mem_write), 32'd0);
      chk("err_mem_addr", mem_addr, 32'd0);
    end else begin
      chk("acc_mem_write", 32'(mem_write), 32'(v.we));
      chk("acc_mem_read", 32'(mem_read), 32'(!v.we));
      chk("acc_mem_addr", mem_addr, v.addr);
      chk("acc_mem_wdata", mem_wdata, v.wdata);
    end
    @(posedge clk);
    @(negedge clk);
    chk("rsp_on_time", 32'(v.port ? rsp1_valid : rsp0_valid), 32'd1);
    $display("txn port=%0d we=%0b addr=%h wdata=%h exp_err=%0b exp_rdata=%h",
             v.port, v.we, v.addr, v.wdata, v.exp_err, v.exp_rdata);
  endtask

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    vec_t rv;
    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h06,  32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h3C,  32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h3C,  32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 1'b1, 32'hC0,  32'h0BADF00D, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'hC0,  32'h0,        1'b0, 32'h0BADF00D};
    vecs[8]  = '{1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'h1000003F};
    vecs[10] = '{1'b1, 1'b0, 32'h00,  32'h0,        1'b0, 32'h10000000};

    idle_inputs();
    reset    = 1'b1;
    mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("reset_mem_out", mem_addr | mem_wdata | 32'(mem_read) | 32'(mem_write), 32'd0);
    chk("reset_rsp_out", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}) | rsp0_rdata | rsp1_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) do_req(vecs[i]);

    // Contention: port 0 wins now, port 1 three cycles later.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h04, 32'h0);
    drive(1'b1, 1'b0, 32'h08, 32'h0);
    @(negedge clk);
    chk("cont_ready0", 32'(req0_ready), 32'd1);
    chk("cont_ready1", 32'(req1_ready), 32'd0);
    sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h10000001});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cnt++;
      if (req1_ready) break;
    end
    chk("cont_gap", 32'(cnt), 32'd3);
    sb.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h10000002});
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(negedge clk);
    $display("txn contention p0 0x04 then p1 0x08 gap=%0d", cnt);

    // Reset during the ACCESS cycle of a write aborts it with no response.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h20, 32'h12345678);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cnt++;
      if (req0_ready) break;
    end
    chk("rst_ready_wait", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rst_pre_write", 32'(mem_write), 32'd1);
    chk("rst_pre_addr", mem_addr, 32'h20);
    #1 reset = 1'b1;
    #1;
    chk("rst_write_drop", 32'(mem_write), 32'd0);
    chk("rst_addr_drop", mem_addr | mem_wdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    end
    $display("txn reset during write access to 0x20");
    rv = '{1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h10000008};
    do_req(rv);

    // Quiet bus.
    repeat (10) begin
      @(negedge clk);
      chk("idle_quiet", mem_addr | mem_wdata | 32'({mem_read, mem_write, rsp0_valid, rsp1_valid}), 32'd0);
    end
    $display("txn idle 10 cycles");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
